// File: rtl/sqrt_pkg.sv
// Shared Q8.8 format constants and controller state encoding for the sqrt stream block.
package sqrt_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FRAC_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } sqrt_state_e;

endpackage

// File: rtl/fixed_sqrt.sv
// Iterative unsigned fixed-point square root: one result bit per cycle after a start pulse.
// Result is floor(sqrt(x_in * 2^FRAC_BITS)), so Q8.8 in gives Q8.8 out; done pulses for one cycle.
module fixed_sqrt #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] x_in,
    output logic [DATA_W-1:0] sqrt_out,
    output logic              done
);

    localparam int unsigned RAD_W  = DATA_W + FRAC_BITS;
    localparam int unsigned ROOT_W = RAD_W / 2;
    localparam int unsigned REM_W  = ROOT_W + 2;
    localparam int unsigned CNT_W  = $clog2(ROOT_W);

    logic              busy;
    logic [CNT_W-1:0]  iter;
    logic [RAD_W-1:0]  rad;
    logic [REM_W-1:0]  rem;
    logic [ROOT_W-1:0] root;

    logic [REM_W+1:0]  rem_sh;
    logic [REM_W+1:0]  trial;
    logic [REM_W-1:0]  rem_nxt;
    logic [ROOT_W-1:0] root_nxt;

    // One digit-by-digit step: bring down two radicand bits, try subtracting 4*root+1.
    always_comb begin
        rem_sh   = {rem, rad[RAD_W-1 -: 2]};
        trial    = {2'b00, root, 2'b01};
        rem_nxt  = REM_W'(rem_sh);
        root_nxt = {root[ROOT_W-2:0], 1'b0};
        if (rem_sh >= trial) begin
            rem_nxt  = REM_W'(rem_sh - trial);
            root_nxt = {root[ROOT_W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            iter     <= '0;
            rad      <= '0;
            rem      <= '0;
            root     <= '0;
            sqrt_out <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                rad  <= rad << 2;
                rem  <= rem_nxt;
                root <= root_nxt;
                iter <= iter - 1'b1;
                if (iter == '0) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    sqrt_out <= DATA_W'(root_nxt);
                end
            end else if (start) begin
                rad  <= {x_in, {FRAC_BITS{1'b0}}};
                rem  <= '0;
                root <= '0;
                iter <= CNT_W'(ROOT_W - 1);
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_stream_master.sv
// Valid/ready wrapper driving a fixed_sqrt engine, one operation in flight at a time.
// Optional WAIT watchdog enabled by defining SQRT_TIMEOUT_EN.
module sqrt_stream_master #(
    parameter int unsigned DATA_W      = sqrt_pkg::DATA_W,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [15:0]       done_cnt
);

    import sqrt_pkg::*;

    sqrt_state_e       state;
    logic [DATA_W-1:0] operand;
    logic              eng_start;
    logic              eng_done;
    logic [DATA_W-1:0] eng_out;

`ifdef SQRT_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    assign out_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign out_err        = 1'b0;
`endif

    fixed_sqrt #(
        .DATA_W   (DATA_W),
        .FRAC_BITS(FRAC_BITS)
    ) u_sqrt (
        .clk     (clk),
        .rst     (rst),
        .start   (eng_start),
        .x_in    (operand),
        .sqrt_out(eng_out),
        .done    (eng_done)
    );

    // Controller: every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            done_cnt  <= '0;
            eng_start <= 1'b0;
            operand   <= '0;
`ifdef SQRT_TIMEOUT_EN
            wait_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        operand   <= in_data;
                        eng_start <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    eng_start <= 1'b0;
                    state     <= WAIT;
`ifdef SQRT_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                end
                WAIT: begin
                    if (eng_done) begin
                        out_data  <= eng_out;
                        out_valid <= 1'b1;
                        state     <= OUT;
`ifdef SQRT_TIMEOUT_EN
                        err_q     <= 1'b0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        out_data  <= '0;
                        err_q     <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
`endif
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        done_cnt  <= done_cnt + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sqrt_stream_master.md
SQRT_STREAM_MASTER -- requirements
Module: sqrt_stream_master

Interface
REQ-001 SHALL have parameter DATA_W, default 16, Q8.8 operand/result width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1023, watchdog limit in cycles (used only with SQRT_TIMEOUT_EN).
REQ-003 SHALL have clk  input  1  single clock, rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have in_valid  input  1  upstream operand valid.
REQ-006 SHALL have in_ready  output  1  block accepts operand.
REQ-007 SHALL have in_data  input  DATA_W  Q8.8 unsigned operand.
REQ-008 SHALL have out_valid  output  1  result valid.
REQ-009 SHALL have out_ready  input  1  downstream accepts result.
REQ-010 SHALL have out_data  output  DATA_W  Q8.8 sqrt result.
REQ-011 SHALL have out_err  output  1  result invalid (timeout), qualified by out_valid.
REQ-012 SHALL have done_cnt  output  16  count of results delivered.

Function
REQ-013 SHALL act as initiator of the engine start/done handshake, driving the internal fixed_sqrt instance's start, x_in, clk, rst and sampling its sqrt_out, done.
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, OUT.
REQ-015 In IDLE: in_ready=1; in_valid&in_ready captures in_data into an operand register and moves to ISSUE.
REQ-016 In ISSUE: engine start=1 for exactly one cycle with x_in=operand register; next state WAIT.
REQ-017 In WAIT: done=1 latches sqrt_out into the result register, clears out_err, moves to OUT; done is ignored in every other state.
REQ-018 In OUT: out_valid=1, out_data/out_err stable; out_valid&out_ready returns to IDLE and increments done_cnt (wraps 0xFFFF->0x0000).
REQ-019 in_ready SHALL be 0 in ISSUE, WAIT, OUT; only one operation in flight.
REQ-020 Minimum latency from input accept to out_valid SHALL be engine latency + 2 cycles; with out_ready held high, back-to-back throughput is one result per engine latency + 3 cycles.
REQ-021 Engine start SHALL never be asserted outside ISSUE.
REQ-022 Operand register SHALL be unchanged from capture until the next IDLE accept.

Reset
REQ-023 On rst: state=IDLE, in_ready=1 after release, out_valid=0, out_data=0, out_err=0, done_cnt=0, engine start=0, operand=0.
REQ-024 rst asserted mid-operation (any state) SHALL abandon the operation with no result emitted; the engine is reset by the same rst.

Configuration
REQ-025 Macro SQRT_TIMEOUT_EN defined: a WAIT-state cycle counter (reset on WAIT entry) reaching TIMEOUT_CYC without done SHALL force OUT with out_data=0, out_err=1.
REQ-026 SQRT_TIMEOUT_EN undefined: no counter logic; WAIT persists until done; out_err tied 0.

Structure
REQ-027 State enum, Q8.8 format constants (DATA_W, FRAC_BITS=8) SHALL live in shared package sqrt_pkg.
REQ-028 SHALL instantiate exactly one sub-module, fixed_sqrt, unchanged.

Verification
REQ-029 in_data=0x0400 (4.0), out_ready=1 -> out_data=0x0200, out_err=0, done_cnt=1.
REQ-030 in_data=0x0000 then 0xFFFF back-to-back -> out_data=0x0000 then within 1% of 0x0FFF, in order, done_cnt=2.
REQ-031 in_data=0x0100, out_ready=0 for 20 cycles -> out_valid held, out_data=0x0100 stable, in_ready=0 throughout; accept on out_ready=1.
REQ-032 rst pulse during WAIT -> out_valid never asserts for that operand; next input 0x1900 (25.0) -> 0x0500.
REQ-033 SQRT_TIMEOUT_EN, TIMEOUT_CYC=8, engine done forced 0 -> out_valid after 8 WAIT cycles with out_err=1, out_data=0.
REQ-034 100 random operands with random out_ready -> every result within 1% of real sqrt, start pulses == results, no start outside ISSUE.
